// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm clock ringer: time match detect, ring/snooze FSM, buzzer drive
module alarm_ringer #(
   parameter int RING_TICKS   = 180,
   parameter int SNOOZE_TICKS = 900,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic       clock,
   input  logic       reset_alarm,
   input  logic       alarm_enable,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [5:0] alarm_hour,
   input  logic [5:0] alarm_min,
   input  logic       stop_alarm,
   input  logic       snooze,
   output logic       ringing,
   output logic       buzzer,
   output logic       snooze_active,
   output logic [1:0] snooze_count,
   output logic       alarm_fired
);

   typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

   localparam logic [11:0] RING_LAST   = 12'(RING_TICKS - 1);
   localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_TICKS - 1);
   localparam logic [1:0]  SNOOZE_MAX  = 2'(MAX_SNOOZE);

   state_t      state, next_state;
   logic [11:0] timer, next_timer;
   logic [1:0]  count, next_count;
   logic        enter_ring;
   logic        fired_q, buzz_q;
   logic        match, match_d, stop_d, snooze_d;
   logic        match_rise, stop_rise, snooze_rise;

   assign match       = (cur_hour == alarm_hour) & (cur_min == alarm_min) & (cur_sec == 6'd0);
   assign match_rise  = match & ~match_d;
   assign stop_rise   = stop_alarm & ~stop_d;
   assign snooze_rise = snooze & ~snooze_d;

   always_ff @(posedge clock) begin
      if (reset_alarm) begin
         state    <= IDLE;
         timer    <= 12'd0;
         count    <= 2'd0;
         fired_q  <= 1'b0;
         buzz_q   <= 1'b0;
         match_d  <= 1'b0;
         stop_d   <= 1'b0;
         snooze_d <= 1'b0;
      end else begin
         state    <= next_state;
         timer    <= next_timer;
         count    <= next_count;
         fired_q  <= enter_ring;
         // Buzzer restarts high on every ring entry, then alternates while ringing
         buzz_q   <= enter_ring ? 1'b1 : ((next_state == RING) ? ~buzz_q : 1'b0);
         match_d  <= match;
         stop_d   <= stop_alarm;
         snooze_d <= snooze;
      end
   end

   always_comb begin
      next_state = state;
      next_timer = timer;
      next_count = count;
      enter_ring = 1'b0;
      case (state)
         IDLE: begin
            if (alarm_enable && match_rise) begin
               next_state = RING;
               next_timer = 12'd0;
               next_count = 2'd0;
               enter_ring = 1'b1;
            end
         end
         RING: begin
            if (!alarm_enable || stop_rise) begin
               next_state = IDLE;
            end else if (snooze_rise && (count < SNOOZE_MAX)) begin
               next_state = SNOOZE;
               next_count = count + 2'd1;
               next_timer = 12'd0;
            end else if (timer == RING_LAST) begin
               next_state = IDLE;
            end else begin
               next_timer = timer + 12'd1;
            end
         end
         SNOOZE: begin
            if (!alarm_enable || stop_rise) begin
               next_state = IDLE;
            end else if (timer == SNOOZE_LAST) begin
               next_state = RING;
               next_timer = 12'd0;
               enter_ring = 1'b1;
            end else begin
               next_timer = timer + 12'd1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ringing       = (state == RING);
      snooze_active = (state == SNOOZE);
      buzzer        = buzz_q;
      alarm_fired   = fired_q;
      snooze_count  = count;
   end

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed self-checking bench for alarm_ringer
module tb_alarm_ringer;

   logic       clock = 1'b0;
   logic       reset_alarm, alarm_enable, stop_alarm, snooze;
   logic [5:0] cur_hour, cur_min, cur_sec, alarm_hour, alarm_min;
   logic       ringing, buzzer, snooze_active, alarm_fired;
   logic [1:0] snooze_count;

   int total = 0;
   int bad   = 0;
   int n;

   alarm_ringer #(.RING_TICKS(180), .SNOOZE_TICKS(900), .MAX_SNOOZE(3)) dut (
      .clock(clock), .reset_alarm(reset_alarm), .alarm_enable(alarm_enable),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .stop_alarm(stop_alarm), .snooze(snooze),
      .ringing(ringing), .buzzer(buzzer), .snooze_active(snooze_active),
      .snooze_count(snooze_count), .alarm_fired(alarm_fired)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hour = 6'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
   endtask

   // Re-arm the match edge: leave 07:30:00 for one cycle, then return to it
   task automatic fire_0730();
      set_time(7, 30, 1);
      step();
      set_time(7, 30, 0);
      step();
   endtask

   task automatic count_while_ringing(output int cnt);
      cnt = 0;
      while (ringing && cnt < 5000) begin
         cnt++;
         step();
      end
   endtask

   task automatic count_while_snoozing(output int cnt);
      cnt = 0;
      while (snooze_active && cnt < 5000) begin
         cnt++;
         step();
      end
   endtask

   task automatic press_snooze();
      snooze = 1'b1;
      step();
      snooze = 1'b0;
   endtask

   initial begin
      reset_alarm  = 1'b1;
      alarm_enable = 1'b1;
      stop_alarm   = 1'b0;
      snooze       = 1'b0;
      alarm_hour   = 6'd7;
      alarm_min    = 6'd30;
      set_time(7, 29, 59);
      step();
      step();
      chk("rst_ringing", ringing, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_snooze_active", snooze_active, 0);
      chk("rst_count", snooze_count, 0);
      chk("rst_fired", alarm_fired, 0);
      reset_alarm = 1'b0;
      step();
      chk("idle_no_match", ringing, 0);

      // Basic ring and auto-stop
      set_time(7, 30, 0);
      step();
      chk("ring_entry", ringing, 1);
      chk("ring_fired", alarm_fired, 1);
      chk("ring_buzz0", buzzer, 1);
      step();
      chk("ring_fired_pulse", alarm_fired, 0);
      chk("ring_buzz1", buzzer, 0);
      step();
      chk("ring_buzz2", buzzer, 1);
      count_while_ringing(n);
      chk("ring_duration", n + 2, 180);
      chk("auto_stop_buzz", buzzer, 0);
      step();
      step();
      chk("held_match_no_refire", ringing, 0);

      // Snooze cycles up to the limit
      fire_0730();
      chk("ring2_entry", ringing, 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         press_snooze();
         chk("snz_active", snooze_active, 1);
         chk("snz_ringing", ringing, 0);
         chk("snz_buzzer", buzzer, 0);
         chk("snz_count", snooze_count, k);
         count_while_snoozing(n);
         chk("snz_duration", n, 900);
         chk("snz_rering", ringing, 1);
         chk("snz_rering_fired", alarm_fired, 1);
         chk("snz_rering_buzz", buzzer, 1);
      end
      press_snooze();
      chk("snz4_ignored_ring", ringing, 1);
      chk("snz4_ignored_sa", snooze_active, 0);
      chk("snz4_count", snooze_count, 3);

      // Stop held: single action, no re-fire on held match, count kept
      stop_alarm = 1'b1;
      step();
      chk("stop_idle", ringing, 0);
      chk("stop_keeps_count", snooze_count, 3);
      for (int k = 0; k < 9; k++) step();
      chk("stop_held_no_refire", ringing, 0);
      stop_alarm = 1'b0;
      step();
      chk("stop_release_no_refire", ringing, 0);

      // Disabled alarm does not fire
      alarm_enable = 1'b0;
      fire_0730();
      chk("disabled_no_ring", ringing, 0);
      step();
      chk("disabled_no_ring2", ringing, 0);

      // Enable dropped during snooze
      alarm_enable = 1'b1;
      fire_0730();
      chk("new_event_count_clear", snooze_count, 0);
      press_snooze();
      for (int k = 0; k < 5; k++) step();
      chk("snz_mid", snooze_active, 1);
      alarm_enable = 1'b0;
      step();
      chk("dis_snz_sa", snooze_active, 0);
      chk("dis_snz_ring", ringing, 0);
      chk("dis_snz_buzz", buzzer, 0);
      chk("dis_snz_fired", alarm_fired, 0);

      // Reset during ring with two snoozes used
      alarm_enable = 1'b1;
      fire_0730();
      for (int k = 0; k < 2; k++) begin
         press_snooze();
         count_while_snoozing(n);
      end
      chk("pre_rst_count", snooze_count, 2);
      step();
      step();
      reset_alarm = 1'b1;
      step();
      chk("midrst_ring", ringing, 0);
      chk("midrst_buzz", buzzer, 0);
      chk("midrst_count", snooze_count, 0);
      chk("midrst_sa", snooze_active, 0);
      chk("midrst_fired", alarm_fired, 0);
      reset_alarm = 1'b0;
      step();
      chk("post_rst_match_fires", ringing, 1);
      chk("post_rst_fired", alarm_fired, 1);
      stop_alarm = 1'b1;
      step();
      stop_alarm = 1'b0;
      chk("post_rst_stop", ringing, 0);

      // Midnight wrap
      alarm_hour = 6'd23;
      alarm_min  = 6'd59;
      set_time(23, 59, 59);
      step();
      set_time(0, 0, 0);
      step();
      chk("wrap_no_fire", ringing, 0);
      step();
      chk("wrap_no_fire2", ringing, 0);
      alarm_hour = 6'd0;
      alarm_min  = 6'd0;
      set_time(23, 59, 59);
      step();
      set_time(0, 0, 0);
      step();
      chk("midnight_fire", ringing, 1);
      chk("midnight_fired", alarm_fired, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter RING_TICKS, 180, clock cycles a ring lasts before auto-stop (legal 2..4095).
REQ-002 Parameter SNOOZE_TICKS, 900, clock cycles a snooze lasts before re-ring (legal 2..4095).
REQ-003 Parameter MAX_SNOOZE, 3, maximum snoozes per alarm event (legal 0..3).
REQ-004 clock  in  1  single clock, divided tick from FPGA frequency divider; all logic on rising edge.
REQ-005 reset_alarm  in  1  synchronous, active-high reset.
REQ-006 alarm_enable  in  1  alarm armed when high.
REQ-007 cur_hour  in  6  current time hour, 0..23.
REQ-008 cur_min  in  6  current time minute, 0..59.
REQ-009 cur_sec  in  6  current time second, 0..59.
REQ-010 alarm_hour  in  6  stored alarm hour, 0..23, from the alarm-hour setter.
REQ-011 alarm_min  in  6  stored alarm minute, 0..59, from the alarm-minute setter.
REQ-012 stop_alarm  in  1  stop button, level; acted on at rising edge only.
REQ-013 snooze  in  1  snooze button, level; acted on at rising edge only.
REQ-014 ringing  out  1  high while in RING.
REQ-015 buzzer  out  1  drive to buzzer/LED; toggles every cycle in RING, 0 otherwise.
REQ-016 snooze_active  out  1  high while in SNOOZE.
REQ-017 snooze_count  out  2  snoozes used in current alarm event.
REQ-018 alarm_fired  out  1  one-cycle pulse on every entry into RING.

Function
REQ-019 match = (cur_hour==alarm_hour) & (cur_min==alarm_min) & (cur_sec==0), 6-bit unsigned compare, combinational.
REQ-020 match_d, stop_d, snooze_d registered every cycle; rises = signal & ~registered copy.
REQ-021 FSM states IDLE, RING, SNOOZE; one internal timer (12-bit) and snooze counter (2-bit).
REQ-022 IDLE: alarm_enable & match rise -> RING, timer=0, snooze_count=0, alarm_fired=1 next cycle; else stay.
REQ-023 RING exits, priority high to low: ~alarm_enable -> IDLE; stop rise -> IDLE; snooze rise & snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1, timer=0; timer==RING_TICKS-1 -> IDLE; else timer+1.
REQ-024 RING: snooze rise with snooze_count==MAX_SNOOZE ignored (keeps ringing, timer continues).
REQ-025 SNOOZE exits, priority: ~alarm_enable -> IDLE; stop rise -> IDLE; timer==SNOOZE_TICKS-1 -> RING, timer=0, alarm_fired pulse; else timer+1; snooze rise ignored.
REQ-026 match rise in RING or SNOOZE ignored (no restart, no counter change).
REQ-027 Latency: ringing and alarm_fired high on the cycle after the edge sampling match rise; exits take effect one cycle after the sampling edge.
REQ-028 Ring duration exactly RING_TICKS cycles of ringing=1 absent buttons; snooze exactly SNOOZE_TICKS cycles of snooze_active=1.
REQ-029 buzzer=1 on first RING cycle, inverts each cycle in RING, forced 0 on any non-RING cycle.
REQ-030 snooze_count holds value in IDLE until next alarm event clears it.
REQ-031 Buttons held high produce one action only; new action needs release then press.
REQ-032 Match held across many cycles (slow time tick) fires once; stopping during a held match does not re-fire.

Reset
REQ-033 reset_alarm high at rising edge: state=IDLE, timer=0, snooze_count=0, ringing=0, buzzer=0, snooze_active=0, alarm_fired=0, match_d/stop_d/snooze_d=0.
REQ-034 Reset overrides all other inputs, including mid-RING and mid-SNOOZE.
REQ-035 If match is high on first cycle after reset, it counts as a rise and fires (if enabled).

Verification
REQ-036 alarm 07:30, enable=1, time steps to 07:30:00 -> ringing=1 next cycle, alarm_fired one pulse, buzzer 1,0,1,..., auto-stop after exactly 180 cycles.
REQ-037 During RING press snooze -> SNOOZE for 900 cycles, snooze_count=1, then RING with alarm_fired pulse; repeat to count 3; 4th snooze press ignored, ringing stays 1.
REQ-038 stop_alarm held high 10 cycles during RING -> IDLE next cycle; match still true -> no re-fire; snooze_count keeps value.
REQ-039 alarm_enable=0 at 07:30:00 -> no ring; enable dropped mid-SNOOZE -> IDLE next cycle, all outputs 0.
REQ-040 reset_alarm pulsed mid-RING with snooze_count=2 -> all outputs 0, snooze_count=0 next cycle.
REQ-041 alarm 23:59, time wraps 23:59:59 -> 00:00:00 -> no fire; alarm 00:00 fires at 00:00:00.
